// File: rtl/flash_rdcache.sv
// Direct-mapped read-only line cache in front of the SPI flash reader; misses fetch the whole line as a sequential word burst.
// Optional macro FLASH_RDCACHE_INVAL_EN adds an `inval` input that flushes every line.
module flash_rdcache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [23:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [23:0] mem_addr,
    input  logic [31:0] mem_rdata
`ifdef FLASH_RDCACHE_INVAL_EN
    ,
    input  logic        inval
`endif
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int OB = WB + 2;
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 24 - OB - IB;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_cpu_ready;
    logic [31:0]          r_cpu_rdata;
    logic                 r_mem_valid;
    logic [23:0]          r_mem_addr;
    logic [NUM_LINES-1:0] r_valid;
    logic [TW-1:0]        r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES*LINE_WORDS];
    logic [WB-1:0]        r_cnt;
    logic [WB-1:0]        r_loff;
    logic [IB-1:0]        r_lidx;
    logic [TW-1:0]        r_ltag;
    logic                 r_sticky;

    logic [WB-1:0] w_off;
    logic [IB-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic          w_hit;
    logic          w_new_req;
    logic          w_last;
    logic          w_inval;

    assign w_off     = cpu_addr[OB-1:2];
    assign w_idx     = cpu_addr[OB+IB-1:OB];
    assign w_tag     = cpu_addr[23:OB+IB];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_new_req = cpu_valid && !r_cpu_ready && (r_state == S_IDLE);
    assign w_last    = mem_ready && (r_cnt == WB'(LINE_WORDS - 1));

`ifdef FLASH_RDCACHE_INVAL_EN
    assign w_inval = inval;
`else
    assign w_inval = 1'b0;
`endif

    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_new_req && !w_hit) w_next = S_FILL;
            S_FILL:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_valid     <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_new_req && w_hit) begin
                        r_cpu_ready <= 1'b1;
                        r_cpu_rdata <= r_data[{w_idx, w_off}];
                    end else if (w_new_req) begin
                        r_mem_valid    <= 1'b1;
                        r_mem_addr     <= {cpu_addr[23:OB], {OB{1'b0}}};
                        r_cnt          <= '0;
                        r_valid[w_idx] <= 1'b0;
                        r_sticky       <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        r_cnt <= r_cnt + WB'(1);
                        // The address stays on the last word so it never leaves the line.
                        if (w_last) begin
                            r_mem_valid <= 1'b0;
                            if (!r_sticky && !w_inval) r_valid[r_lidx] <= 1'b1;
                        end else begin
                            r_mem_addr <= r_mem_addr + 24'd4;
                        end
                    end
                end
                S_DONE: begin
                    r_cpu_ready <= 1'b1;
                    r_cpu_rdata <= r_data[{r_lidx, r_loff}];
                end
                default: ;
            endcase
            // Placed last so a flush overrides any valid-bit update in the same cycle.
            if (w_inval) begin
                r_valid <= '0;
                if (r_state == S_FILL) r_sticky <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_new_req && !w_hit) begin
            r_lidx <= w_idx;
            r_loff <= w_off;
            r_ltag <= w_tag;
        end
        if (r_state == S_FILL && mem_ready) begin
            r_data[{r_lidx, r_cnt}] <= mem_rdata;
            if (w_last) r_tag[r_lidx] <= r_ltag;
        end
    end
endmodule

// File: tb/tb_flash_rdcache.sv
// Scoreboard bench for flash_rdcache: directed reads, a flash responder model and a cpu_ready monitor.
module tb_flash_rdcache;
    logic        clk;
    logic        resetn;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [23:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata;
`ifdef FLASH_RDCACHE_INVAL_EN
    logic        inval;
`endif

    int total = 0;
    int bad   = 0;
    int mem_words = 0;
    int lat_sel = 0;
    bit stop_mem = 0;
    bit prev_ready = 0;
    logic [31:0] exp_q[$];
    logic [23:0] addr_q[$];

    flash_rdcache #(.LINE_WORDS(4), .NUM_LINES(16)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
`ifdef FLASH_RDCACHE_INVAL_EN
        , .inval(inval)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash model: each word is 0xD0 followed by its 24-bit address.
    initial begin
        mem_ready = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_valid && !stop_mem && resetn) begin
                if (addr_q.size() == 0) chk("mem_unexpected_req", 1, 0);
                else chk("mem_addr", mem_addr, addr_q.pop_front());
                repeat (lat_sel % 3) @(negedge clk);
                lat_sel++;
                mem_ready = 1;
                mem_rdata = {8'hD0, mem_addr};
                @(negedge clk);
                mem_ready = 0;
                mem_words++;
            end
        end
    end

    always @(negedge clk) begin
        if (cpu_ready) begin
            chk("ready_pulse", prev_ready, 0);
            if (exp_q.size() == 0) chk("unexpected_ready", 1, 0);
            else chk("cpu_rdata", cpu_rdata, exp_q.pop_front());
        end
        prev_ready = cpu_ready;
    end

    task automatic do_read(input logic [23:0] a, input logic [31:0] d, input bit miss,
                           input logic [23:0] base);
        int cyc;
        int w0;
        exp_q.push_back(d);
        if (miss) for (int i = 0; i < 4; i++) addr_q.push_back(base + 24'(4 * i));
        w0 = mem_words;
        @(posedge clk); #1;
        cpu_valid = 1;
        cpu_addr  = a;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!cpu_ready && cyc < 200);
        cpu_valid = 0;
        chk("ready_seen", cpu_ready, 1);
        if (miss) begin
            chk("fill_words", mem_words - w0, 4);
        end else begin
            chk("hit_latency", cyc, 1);
            chk("hit_no_mem", mem_words - w0, 0);
            chk("hit_mem_valid", mem_valid, 0);
        end
    endtask

    task automatic wait_words(input int n);
        int cyc;
        cyc = 0;
        while (mem_words < n && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wait_words", mem_words >= n, 1);
    endtask

    initial begin
        int w0;
        resetn    = 0;
        cpu_valid = 0;
        cpu_addr  = '0;
`ifdef FLASH_RDCACHE_INVAL_EN
        inval = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        resetn = 1;

        do_read(24'h000104, 32'hD000_0104, 1, 24'h000100);
        do_read(24'h00010C, 32'hD000_010C, 0, 24'h000000);
        do_read(24'h000100, 32'hD000_0100, 0, 24'h000000);
        do_read(24'h001100, 32'hD000_1100, 1, 24'h001100);
        do_read(24'h001108, 32'hD000_1108, 0, 24'h000000);
        do_read(24'h000100, 32'hD000_0100, 1, 24'h000100);
        do_read(24'hFFFFF8, 32'hD0FF_FFF8, 1, 24'hFFFFF0);
        do_read(24'hFFFFF4, 32'hD0FF_FFF4, 0, 24'h000000);
        do_read(24'h000107, 32'hD000_0104, 0, 24'h000000);

        // Reset in the middle of a fill: two words land, then the fill is abandoned.
        w0 = mem_words;
        for (int i = 0; i < 4; i++) addr_q.push_back(24'h000300 + 24'(4 * i));
        @(posedge clk); #1;
        cpu_valid = 1;
        cpu_addr  = 24'h000304;
        wait_words(w0 + 2);
        stop_mem  = 1;
        resetn    = 0;
        cpu_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_mem_valid", mem_valid, 0);
        chk("midrst_cpu_ready", cpu_ready, 0);
        exp_q.delete();
        addr_q.delete();
        resetn   = 1;
        stop_mem = 0;
        do_read(24'h000304, 32'hD000_0304, 1, 24'h000300);
        do_read(24'h000308, 32'hD000_0308, 0, 24'h000000);
        do_read(24'h00010C, 32'hD000_010C, 1, 24'h000100);

`ifdef FLASH_RDCACHE_INVAL_EN
        do_read(24'h000200, 32'hD000_0200, 1, 24'h000200);
        @(posedge clk); #1 inval = 1;
        @(posedge clk); #1 inval = 0;
        do_read(24'h000200, 32'hD000_0200, 1, 24'h000200);
        w0 = mem_words;
        fork
            do_read(24'h000404, 32'hD000_0404, 1, 24'h000400);
            begin
                wait_words(w0 + 1);
                inval = 1;
                @(posedge clk); #1 inval = 0;
            end
        join
        do_read(24'h000404, 32'hD000_0404, 1, 24'h000400);
`endif

        repeat (4) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flash_rdcache.md
Name: flash_rdcache

Overview:
- Direct-mapped, read-only line cache between the CPU instruction/data fetch bus and the SPI flash reader.
- Consumes CPU word reads and serves hits locally.
- On a miss, issues a strictly sequential burst of word reads for the whole line downstream. This lets the flash reader's address-continuation and prefetch path stream the line without re-sending commands.

Parameters:
- LINE_WORDS, 4: 32-bit words per line. Power of two, at least 2.
- NUM_LINES, 16: number of lines. Power of two, at least 2.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- cpu_valid  input  1  CPU read request; held until cpu_ready
- cpu_ready  output  1  one-cycle pulse; cpu_rdata valid in the same cycle
- cpu_addr  input  24  CPU byte address; bits [1:0] ignored
- cpu_rdata  output  32  read data
- mem_valid  output  1  downstream read request
- mem_ready  input  1  downstream one-cycle completion pulse
- mem_addr  output  24  downstream word-aligned byte address
- mem_rdata  input  32  downstream data, valid when mem_ready=1

Interface (already decided): one clock, clk. Reset is resetn: synchronous, active-low.

Behaviour:
- Address split:
  - OB = log2(LINE_WORDS)+2; IB = log2(NUM_LINES).
  - offset = cpu_addr[OB-1:2]; index = cpu_addr[OB+IB-1:OB]; tag = cpu_addr[23:OB+IB].
- Storage: per line, a valid bit, a tag register and a LINE_WORDS x 32 data array.
- Reset (resetn=0 at an edge):
  - cpu_ready=0, mem_valid=0, mem_addr=0, cpu_rdata=0.
  - All valid bits cleared; state=IDLE; fill counter=0.
  - Reset mid-fill abandons the fill; no partial line is marked valid.
- New request: cpu_valid && !cpu_ready in IDLE. A request is never re-triggered in its own ready cycle.
- State IDLE:
  - New request that hits (valid[index] && tag match): next edge cpu_ready=1 and cpu_rdata=data[index][offset]. Hit latency is 1 cycle. State stays IDLE.
  - New request that misses: next edge state=FILL, mem_valid=1, mem_addr={cpu_addr[23:OB], OB'b0}, fill counter=0, valid[index] cleared. The request's address is latched.
- State FILL:
  - mem_valid stays 1 until the last word is accepted.
  - On each mem_ready: write mem_rdata to data[index][counter]; counter+1; mem_addr+4 at the same edge.
  - On mem_ready with counter==LINE_WORDS-1: mem_valid=0, tag and valid[index] written, state=DONE.
  - mem_addr never crosses the line. Line 0xFFFFF0 ends at 0xFFFFFC with no 24-bit overflow.
- State DONE: next edge cpu_ready=1, cpu_rdata=data word for the latched offset, state=IDLE.
  - Miss latency = 1 + sum of downstream latencies + 1 cycles.
- cpu_ready is never high for two consecutive cycles.
- cpu_rdata holds its value when cpu_ready=0.
- CPU protocol violation: cpu_valid dropped or cpu_addr changed during FILL. The fill still completes with the latched address. DONE still pulses cpu_ready; the master ignores it.
- mem_ready while mem_valid=0 is ignored.
- Only one outstanding downstream request at a time.

Optional Feature:
- Macro: FLASH_RDCACHE_INVAL_EN.
- Defined:
  - Adds input port inval (1 bit).
  - inval=1 at an edge clears all valid bits.
  - In FILL it also sets a sticky flag so the line being filled is not marked valid at completion. The pending request is still answered with the filled data.
  - A hit lookup in the same cycle as inval is evaluated against the pre-clear state.
- Not defined: no inval port. Valid bits change only on reset and fills.

Test Plan:
- Cold miss: read 0x000104 after reset.
  - Required: mem_addr sequence 0x000100, 0x000104, 0x000108, 0x00010C; mem_valid drops after the 4th mem_ready.
  - Required: cpu_ready with cpu_rdata equal to the word returned for 0x000104.
- Hit after fill: read 0x00010C.
  - Required: cpu_ready exactly 1 cycle after cpu_valid; mem_valid stays 0; data is the 4th fill word.
- Conflict: read 0x000100, then 0x001100 (same index 0, different tag).
  - Required: second read refills from 0x001100.
  - Required: a re-read of 0x000100 misses again.
- Top of space: read 0xFFFFF8.
  - Required: fill 0xFFFFF0..0xFFFFFC; no wrap to 0x000000; data for 0xFFFFF8 returned.
- Reset mid-fill: assert resetn=0 after 2 of 4 mem_ready pulses, then release.
  - Required: mem_valid=0, cpu_ready=0.
  - Required: a read of the same line misses and refills all 4 words.
- Inval (macro defined): fill line 0x000200, pulse inval.
  - Required: read 0x000200 misses.
  - Required: inval during a fill leaves that line invalid afterwards.
